// File: rtl/sqrt_pkg.sv
// Shared definitions for the round-robin square-root scheduler: default widths,
// iteration register widths and the FSM state encoding.
package sqrt_pkg;
  localparam int NUM_W_DEF = 7;
  localparam int RES_W_DEF = 4;
  localparam int SQ_W      = 8;
  localparam int D_W       = 5;
  localparam int OWN_W     = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/sqrt_rr_sched_if.sv
// Requester-side bundle of the scheduler: request levels, packed operands and the
// registered grant/completion outputs.
interface sqrt_rr_sched_if #(
  parameter int N_REQ = 4,
  parameter int NUM_W = sqrt_pkg::NUM_W_DEF,
  parameter int RES_W = sqrt_pkg::RES_W_DEF
);
  logic [N_REQ-1:0]         req;
  logic [N_REQ*NUM_W-1:0]   num;
  logic [N_REQ-1:0]         ack;
  logic [N_REQ-1:0]         done;
  logic [RES_W-1:0]         result;
  logic [sqrt_pkg::OWN_W-1:0] owner;
  logic                     busy;

  modport master (output req, num, input ack, done, result, owner, busy);
  modport slave  (input req, num, output ack, done, result, owner, busy);
endinterface

// File: rtl/sqrt_iter_core.sv
// Odd-number-sum integer square root: sq tracks (r+1)^2 and d the next odd step,
// so the loop ends on the first cycle where sq exceeds the captured operand.
module sqrt_iter_core import sqrt_pkg::*; #(
  parameter int NUM_W = NUM_W_DEF,
  parameter int RES_W = RES_W_DEF
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             load,
  input  logic             step,
  input  logic [NUM_W-1:0] operand,
  output logic [RES_W-1:0] r,
  output logic             sq_gt
);
  logic [NUM_W-1:0] op_q;
  logic [SQ_W-1:0]  sq;
  logic [D_W-1:0]   d;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      op_q <= '0;
      r    <= '0;
      sq   <= '0;
      d    <= '0;
    end else if (load) begin
      op_q <= operand;
      r    <= '0;
      sq   <= SQ_W'(1);
      d    <= D_W'(3);
    end else if (step) begin
      r    <= r + 1'b1;
      sq   <= sq + SQ_W'(d);
      d    <= d + D_W'(2);
    end
  end

  assign sq_gt = sq > SQ_W'(op_q);
endmodule

// File: rtl/sqrt_rr_sched.sv
// Round-robin arbiter sharing one iterative square-root engine among N_REQ requesters.
// state | meaning
// IDLE  | waiting; grants first active req at or above rr_ptr
// CALC  | engine iterating on the granted operand
// DONE  | result published; advance rr_ptr past owner
module sqrt_rr_sched import sqrt_pkg::*; #(
  parameter int N_REQ = 4,
  parameter int NUM_W = NUM_W_DEF,
  parameter int RES_W = RES_W_DEF
) (
  input  logic            clk,
  input  logic            clear,
  sqrt_rr_sched_if.slave  bus
);
  localparam int CW = OWN_W + 1;

  state_t               state, state_nxt;
  logic [OWN_W-1:0]     rr_ptr, rr_ptr_nxt, owner_nxt, gnt;
  logic [CW-1:0]        cand;
  logic                 gnt_vld;
  logic [N_REQ-1:0]     ack_nxt, done_nxt;
  logic [RES_W-1:0]     result_nxt, core_r;
  logic                 core_load, core_step, sq_gt, busy_nxt;
  logic [NUM_W-1:0]     num_arr [N_REQ];

  function automatic logic [OWN_W-1:0] wrap_inc(input logic [OWN_W-1:0] p);
    logic [CW-1:0] s;
    s = {1'b0, p} + CW'(1);
    if (s >= CW'(N_REQ)) s = '0;
    return s[OWN_W-1:0];
  endfunction

  always_comb begin
    for (int k = 0; k < N_REQ; k++) num_arr[k] = bus.num[k*NUM_W +: NUM_W];
  end

  // Rotate the search origin to rr_ptr; the first hit in that order wins.
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    cand    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, rr_ptr} + CW'(k);
      if (cand >= CW'(N_REQ)) cand = cand - CW'(N_REQ);
      if (!gnt_vld && bus.req[cand[OWN_W-1:0]]) begin
        gnt_vld = 1'b1;
        gnt     = cand[OWN_W-1:0];
      end
    end
  end

  sqrt_iter_core #(.NUM_W(NUM_W), .RES_W(RES_W)) u_core (
    .clk     (clk),
    .clear   (clear),
    .load    (core_load),
    .step    (core_step),
    .operand (num_arr[gnt]),
    .r       (core_r),
    .sq_gt   (sq_gt)
  );

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      bus.ack    <= '0;
      bus.done   <= '0;
      bus.result <= '0;
      bus.owner  <= '0;
      bus.busy   <= 1'b0;
    end else begin
      state      <= state_nxt;
      rr_ptr     <= rr_ptr_nxt;
      bus.ack    <= ack_nxt;
      bus.done   <= done_nxt;
      bus.result <= result_nxt;
      bus.owner  <= owner_nxt;
      bus.busy   <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_vld) state_nxt = CALC;
      CALC:    if (sq_gt) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ack_nxt    = '0;
    done_nxt   = '0;
    result_nxt = bus.result;
    owner_nxt  = bus.owner;
    rr_ptr_nxt = rr_ptr;
    core_load  = 1'b0;
    core_step  = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_vld) begin
          ack_nxt[gnt] = 1'b1;
          owner_nxt    = gnt;
          core_load    = 1'b1;
        end
      end
      CALC: begin
        if (sq_gt) begin
          result_nxt          = core_r;
          done_nxt[bus.owner] = 1'b1;
        end else begin
          core_step = 1'b1;
        end
      end
      DONE:    rr_ptr_nxt = wrap_inc(bus.owner);
      default: ;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end
endmodule

// File: tb/tb_sqrt_rr_sched.sv
// Self-checking bench for sqrt_rr_sched: directed scenarios plus random traffic,
// checked against an event-level model of grant order, latency and result.
module tb_sqrt_rr_sched;
  localparam int N  = 4;
  localparam int NW = 7;
  localparam int RW = 4;
  localparam int W  = N * NW;

  logic clk = 1'b0;
  logic clear;
  always #5 clk = ~clk;

  sqrt_rr_sched_if #(.N_REQ(N), .NUM_W(NW), .RES_W(RW)) bus ();
  sqrt_rr_sched #(.N_REQ(N), .NUM_W(NW), .RES_W(RW)) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int isqrt(input int v);
    int r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  function automatic int low_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Reference model state, advanced once per observed cycle.
  int n_cyc, last_done, ack_cyc, job_idx, job_exp, rr_exp;
  bit have_job, warm;
  int wait_jobs [N];
  logic [N-1:0] req_last;
  logic [W-1:0] num_last;
  int grant_log [$];
  int result_log [$];
  int last_res, last_lat, last_idx;

  function automatic int model_grant();
    for (int k = 0; k < N; k++) if (req_last[(rr_exp + k) % N]) return (rr_exp + k) % N;
    return -1;
  endfunction

  always @(negedge clk) begin
    if (clear) begin
      n_cyc = 0; last_done = -100; have_job = 0; rr_exp = 0; warm = 0;
      for (int i = 0; i < N; i++) wait_jobs[i] = 0;
    end else if (!warm) begin
      warm = 1;
    end else begin
      bit exp_ack, exp_done;
      int g, e;
      logic [W-1:0] t;
      n_cyc++;
      exp_ack = !have_job && (n_cyc - last_done >= 2) && (req_last != 0);
      chk("ack_when_expected", bus.ack != 0, exp_ack);
      chk("ack_done_excl", (bus.ack != 0) && (bus.done != 0), 0);
      if (bus.ack != 0) begin
        g = low_idx(bus.ack);
        e = model_grant();
        chk("ack_onehot", $countones(bus.ack), 1);
        chk("grant_idx", g, e);
        chk("fair_wait", wait_jobs[g] < N, 1);
        for (int i = 0; i < N; i++)
          wait_jobs[i] = (i != g && req_last[i]) ? wait_jobs[i] + 1 : 0;
        t = num_last >> (g * NW);
        have_job = 1; job_idx = g; job_exp = isqrt(int'(t[NW-1:0])); ack_cyc = n_cyc;
        grant_log.push_back(g);
      end
      chk("busy", bus.busy, have_job);
      exp_done = have_job && (n_cyc - ack_cyc == job_exp + 1);
      chk("done_when_expected", bus.done != 0, exp_done);
      if (bus.done != 0) begin
        chk("done_onehot", $countones(bus.done), 1);
        chk("done_idx", low_idx(bus.done), job_idx);
        chk("result", bus.result, job_exp);
        chk("owner", bus.owner, job_idx);
        last_res = int'(bus.result); last_lat = n_cyc - ack_cyc; last_idx = low_idx(bus.done);
        result_log.push_back(int'(bus.result));
        have_job = 0; last_done = n_cyc; rr_exp = (job_idx + 1) % N;
      end
    end
    req_last = bus.req;
    num_last = bus.num;
  end

  logic [N-1:0] hold;

  task automatic cyc();
    @(posedge clk);
    #2;
    for (int i = 0; i < N; i++) if (bus.ack[i] && !hold[i]) bus.req[i] = 1'b0;
  endtask

  task automatic idle(input int c);
    repeat (c) cyc();
  endtask

  task automatic set_num(input int i, input int v);
    logic [W-1:0] m, val;
    m   = W'((1 << NW) - 1) << (i * NW);
    val = W'(v) << (i * NW);
    bus.num = (bus.num & ~m) | (val & m);
  endtask

  task automatic wait_done(input int maxc);
    for (int k = 0; k < maxc; k++) begin
      cyc();
      if (bus.done != 0) return;
    end
    chk("timeout_done", 0, 1);
  endtask

  task automatic wait_ack(input int maxc);
    for (int k = 0; k < maxc; k++) begin
      cyc();
      if (bus.ack != 0) return;
    end
    chk("timeout_ack", 0, 1);
  endtask

  task automatic do_reset();
    cyc();
    clear = 1'b1;
    bus.req = '0;
    idle(2);
    clear = 1'b0;
    cyc();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int exp_g [5] = '{0, 1, 2, 3, 0};
    clear = 1'b1; bus.req = '0; bus.num = '0; hold = '0;
    idle(2);
    chk("rst_ack", bus.ack, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_owner", bus.owner, 0);
    chk("rst_busy", bus.busy, 0);
    clear = 1'b0;
    cyc();

    // Zero operand on requester 0
    set_num(0, 0); bus.req[0] = 1'b1;
    wait_done(10); idle(2);
    chk("t1_res", last_res, 0);
    chk("t1_lat", last_lat, 1);
    chk("t1_idx", last_idx, 0);

    // Largest operand on requester 2
    set_num(2, 127); bus.req[2] = 1'b1;
    wait_done(20); idle(2);
    chk("t2_res", last_res, 11);
    chk("t2_lat", last_lat, 12);
    chk("t2_idx", last_idx, 2);

    // All four requesting continuously from rr_ptr 0
    do_reset();
    grant_log.delete(); result_log.delete();
    set_num(0, 16); set_num(1, 25); set_num(2, 36); set_num(3, 49);
    hold = '1; bus.req = '1;
    for (int j = 0; j < 5; j++) wait_done(20);
    bus.req = '0; hold = '0;
    idle(4);
    chk("t3_grant_n", grant_log.size(), 5);
    for (int j = 0; j < 5; j++) chk("t3_grant", grant_log[j], exp_g[j]);
    for (int j = 0; j < 4; j++) chk("t3_res", result_log[j], j + 4);

    // Full operand sweep on requester 1, back to back
    for (int v = 0; v < 128; v++) begin
      set_num(1, v); bus.req[1] = 1'b1;
      wait_done(20); idle(1);
      chk("sweep_res", last_res, isqrt(v));
      chk("sweep_lat", last_lat, isqrt(v) + 1);
    end
    idle(2);

    // Abort mid-job, then a normal job
    set_num(2, 100); bus.req[2] = 1'b1;
    wait_ack(10);
    idle(3);
    clear = 1'b1;
    #1;
    chk("abort_ack", bus.ack, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_result", bus.result, 0);
    chk("abort_owner", bus.owner, 0);
    chk("abort_busy", bus.busy, 0);
    bus.req = '0;
    idle(2);
    clear = 1'b0;
    cyc();
    set_num(3, 9); bus.req[3] = 1'b1;
    wait_done(15); idle(2);
    chk("t5_res", last_res, 3);
    chk("t5_idx", last_idx, 3);

    // req[1] toggles while requester 0 computes; only the IDLE-edge operand counts
    set_num(0, 50); bus.req[0] = 1'b1;
    wait_ack(10);
    cyc(); bus.req[1] = 1'b1; set_num(1, 20);
    idle(2); bus.req[1] = 1'b0;
    cyc(); bus.req[1] = 1'b1; set_num(1, 64);
    wait_done(20);
    set_num(1, 81);
    wait_done(20); idle(2);
    chk("t6_res", last_res, 9);
    chk("t6_idx", last_idx, 1);

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      cyc();
      for (int i = 0; i < N; i++) begin
        if (!bus.req[i] && $urandom_range(3) == 0) begin
          set_num(i, int'($urandom_range(127)));
          bus.req[i] = 1'b1;
        end
      end
    end
    for (int k = 0; k < 400; k++) begin
      if (bus.req == 0 && !bus.busy) break;
      cyc();
    end
    chk("drain", (bus.req == 0) && !bus.busy, 1);
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sqrt_rr_sched.md
SQRT_RR_SCHED -- requirements
Module: sqrt_rr_sched

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one square-root engine (range 2..4).
REQ-002 Parameter NUM_W, default 7: operand width.
REQ-003 Parameter RES_W, default 4: result width.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 clear  input  1  reset, asynchronous, active-high.
REQ-006 req  input  N_REQ  per-requester request level, held high until matching ack.
REQ-007 num  input  N_REQ*NUM_W  packed operands; requester i uses bits [i*NUM_W +: NUM_W].
REQ-008 ack  output  N_REQ  one-hot, one-cycle pulse: request i accepted, operand captured.
REQ-009 done  output  N_REQ  one-hot, one-cycle pulse: result valid for requester i.
REQ-010 result  output  RES_W  floor(sqrt(operand)) of last completed job; held until next done.
REQ-011 owner  output  2  index of requester currently or last served.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 States: IDLE, CALC, DONE; all outputs registered.
REQ-014 IDLE, any req high at edge: grant the first requester with req high, searching upward from rr_ptr with wrap-around; capture its operand, owner <= index, r <= 0, sq <= 1, d <= 3, ack[index] <= 1, go to CALC.
REQ-015 IDLE, no req: stay in IDLE, ack/done 0.
REQ-016 CALC, each edge: if sq <= operand, then r <= r+1, sq <= sq+d, d <= d+2 and stay; else result <= r, done[owner] <= 1, go to DONE.
REQ-017 Widths: sq 8 bits, d 5 bits, r RES_W bits; for operands 0..127 no overflow; result max 11.
REQ-018 Latency: ack high in the cycle after the grant edge; done high floor(sqrt(num))+1 cycles after ack.
REQ-019 DONE: rr_ptr <= owner+1 modulo N_REQ, go to IDLE; done drops after one cycle.
REQ-020 req is sampled only in IDLE; req changes during CALC/DONE are ignored.
REQ-021 req still high in IDLE after its own done is a new request.
REQ-022 Back-to-back: next grant no earlier than the IDLE edge following DONE, so at least 2 cycles from one done to the next ack.
REQ-023 Fairness: a continuously requesting requester is granted within N_REQ jobs.
REQ-024 Simultaneous requests in IDLE: exactly one ack; others wait, no operand loss.
REQ-025 ack and done are never high together; at most one bit of each is high in any cycle.

Reset
REQ-026 clear high: state IDLE, rr_ptr 0, owner 0, result 0, ack 0, done 0, busy 0, internal r/sq/d 0, immediately and independent of clk.
REQ-027 clear during CALC/DONE aborts the job; no done pulse is issued for it.
REQ-028 First rising edge after clear deasserts behaves as IDLE with rr_ptr 0.

Structure
REQ-029 Shared package sqrt_pkg holds NUM_W, RES_W defaults, the state encoding (IDLE, CALC, DONE) and the sq/d widths.
REQ-030 Sub-module sqrt_iter_core holds the r/sq/d registers with load/step inputs and a sq-greater-than-operand flag; sqrt_rr_sched holds the FSM, arbiter and pointer.

Verification
REQ-031 Single req[0], num=0 -> ack[0] one cycle later, done[0] 1 cycle after ack, result=0.
REQ-032 Single req[2], num=127 -> done[2] 12 cycles after ack, result=11, owner=2, busy high from ack through done.
REQ-033 req=4'b1111 all held, nums 16/25/36/49 -> grants in order 0,1,2,3,0; results 4,5,6,7.
REQ-034 Sweep num 0..127 on req[1] -> result = floor(sqrt(num)) every job; done latency = result+1 after ack.
REQ-035 Assert clear 3 cycles into a num=100 job -> outputs 0 immediately, no done; next req[3] num=9 -> result 3 granted normally.
REQ-036 req[1] toggled during CALC of requester 0's job -> ignored until IDLE; then granted with the operand present at that IDLE edge.
